// File: rtl/fetch_predictor.sv
// ============================================================================
// Module      : fetch_predictor
// Description : Fetch-address unit with a direct-mapped BTB and 2-bit
//               saturating direction counters; zero-cycle prediction.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_predictor #(
    parameter int                  DATA_WIDTH = 32,
    parameter int                  ENTRIES    = 16,
    parameter logic [DATA_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  redirect_en,
    input  logic [DATA_WIDTH-1:0] redirect_pc,
    input  logic                  upd_en,
    input  logic [DATA_WIDTH-1:0] upd_pc,
    input  logic                  upd_taken,
    input  logic [DATA_WIDTH-1:0] upd_target,
    output logic [DATA_WIDTH-1:0] PC,
    output logic                  pred_taken,
    output logic [DATA_WIDTH-1:0] pred_target
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = DATA_WIDTH - IDX_W - 2;

    localparam logic [DATA_WIDTH-1:0] c_pc_step   = DATA_WIDTH'(4);
    localparam logic [1:0]            c_ctr_reset = 2'b01;
    localparam logic [1:0]            c_ctr_alloc = 2'b10;
    localparam logic [1:0]            c_ctr_max   = 2'b11;
    localparam logic [1:0]            c_ctr_min   = 2'b00;

    logic [DATA_WIDTH-1:0] r_pc;

    logic [ENTRIES-1:0]    w_valid_vec;
    logic [TAG_W-1:0]      w_tag_arr    [ENTRIES];
    logic [DATA_WIDTH-1:0] w_target_arr [ENTRIES];
    logic [1:0]            w_ctr_arr    [ENTRIES];

    logic [IDX_W-1:0]      w_idx;
    logic [TAG_W-1:0]      w_tag;
    logic                  w_hit;
    logic [DATA_WIDTH-1:0] w_pc_plus4;

    logic [IDX_W-1:0]      w_upd_idx;
    logic [TAG_W-1:0]      w_upd_tag;
    logic                  w_upd_hit;
    logic                  w_unused;

    // Lookup on the current PC always sees the pre-update array contents
    assign w_idx       = r_pc[IDX_W+1:2];
    assign w_tag       = r_pc[DATA_WIDTH-1:IDX_W+2];
    assign w_hit       = w_valid_vec[w_idx] && (w_tag_arr[w_idx] == w_tag);
    assign w_pc_plus4  = r_pc + c_pc_step;

    assign PC          = r_pc;
    assign pred_taken  = w_hit && w_ctr_arr[w_idx][1];
    assign pred_target = pred_taken ? w_target_arr[w_idx] : w_pc_plus4;

    assign w_upd_idx   = upd_pc[IDX_W+1:2];
    assign w_upd_tag   = upd_pc[DATA_WIDTH-1:IDX_W+2];
    assign w_upd_hit   = w_valid_vec[w_upd_idx] && (w_tag_arr[w_upd_idx] == w_upd_tag);

    // Byte-offset bits of word-aligned addresses carry no information
    assign w_unused    = &{1'b0, upd_pc[1:0], redirect_pc[1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= RESET_PC;
        end else if (redirect_en) begin
            r_pc <= {redirect_pc[DATA_WIDTH-1:2], 2'b00};
        end else if (!stall) begin
            r_pc <= pred_target;
        end
    end

    for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
        localparam logic [IDX_W-1:0] c_idx = IDX_W'(gi);

        logic                  r_valid;
        logic [TAG_W-1:0]      r_tag;
        logic [DATA_WIDTH-1:0] r_target;
        logic [1:0]            r_ctr;
        logic                  w_sel;

        assign w_sel             = upd_en && (w_upd_idx == c_idx);
        assign w_valid_vec[gi]   = r_valid;
        assign w_tag_arr[gi]     = r_tag;
        assign w_target_arr[gi]  = r_target;
        assign w_ctr_arr[gi]     = r_ctr;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_valid  <= 1'b0;
                r_tag    <= '0;
                r_target <= '0;
                r_ctr    <= c_ctr_reset;
            end else if (w_sel) begin
                if (w_upd_hit) begin
                    if (upd_taken) begin
                        r_target <= upd_target;
                        if (r_ctr != c_ctr_max) r_ctr <= r_ctr + 2'd1;
                    end else if (r_ctr != c_ctr_min) begin
                        r_ctr <= r_ctr - 2'd1;
                    end
                end else if (upd_taken) begin
                    // Allocation evicts whatever aliased into this slot
                    r_valid  <= 1'b1;
                    r_tag    <= w_upd_tag;
                    r_target <= upd_target;
                    r_ctr    <= c_ctr_alloc;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fetch_predictor.sv
// ============================================================================
// Module      : tb_fetch_predictor
// Description : Directed self-checking bench for fetch_predictor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_predictor;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        redirect_en = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        upd_en = 1'b0;
    logic [31:0] upd_pc = '0;
    logic        upd_taken = 1'b0;
    logic [31:0] upd_target = '0;
    logic [31:0] PC;
    logic        pred_taken;
    logic [31:0] pred_target;

    int n_cmp = 0;
    int n_err = 0;

    fetch_predictor #(
        .DATA_WIDTH (32),
        .ENTRIES    (16),
        .RESET_PC   (32'h0)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .redirect_en (redirect_en),
        .redirect_pc (redirect_pc),
        .upd_en      (upd_en),
        .upd_pc      (upd_pc),
        .upd_taken   (upd_taken),
        .upd_target  (upd_target),
        .PC          (PC),
        .pred_taken  (pred_taken),
        .pred_target (pred_target)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One clock edge; outputs are sampled 1 ns after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic redirect_to(input logic [31:0] addr);
        redirect_en = 1'b1;
        redirect_pc = addr;
        step();
        redirect_en = 1'b0;
    endtask

    // Training while fetch is stalled so PC stays put
    task automatic train(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
        stall      = 1'b1;
        upd_en     = 1'b1;
        upd_pc     = pc;
        upd_taken  = taken;
        upd_target = tgt;
        step();
        upd_en     = 1'b0;
        stall      = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] exp_pc;
        do_reset();
        n_cmp++; if (PC !== 32'h0) begin n_err++; $display("FAIL reset_pc: got %h want %h", PC, 32'h0); end
        n_cmp++; if (pred_target !== 32'h4) begin n_err++; $display("FAIL reset_pred_target: got %h want %h", pred_target, 32'h4); end
        for (int i = 1; i < 4; i++) begin
            step();
            exp_pc = 32'(4 * i);
            n_cmp++; if (PC !== exp_pc) begin n_err++; $display("FAIL free_run_pc[%0d]: got %h want %h", i, PC, exp_pc); end
            n_cmp++; if (pred_taken !== 1'b0) begin n_err++; $display("FAIL free_run_taken[%0d]: got %b want 0", i, pred_taken); end
        end
    endtask

    task automatic test_allocate();
        do_reset();
        train(32'h10, 1'b1, 32'h40);
        n_cmp++; if (PC !== 32'h0) begin n_err++; $display("FAIL alloc_stall_hold: got %h want %h", PC, 32'h0); end
        for (int i = 0; i < 4; i++) step();
        n_cmp++; if (PC !== 32'h10) begin n_err++; $display("FAIL alloc_reach: got %h want %h", PC, 32'h10); end
        n_cmp++; if (pred_taken !== 1'b1) begin n_err++; $display("FAIL alloc_taken: got %b want 1", pred_taken); end
        n_cmp++; if (pred_target !== 32'h40) begin n_err++; $display("FAIL alloc_target: got %h want %h", pred_target, 32'h40); end
        step();
        n_cmp++; if (PC !== 32'h40) begin n_err++; $display("FAIL alloc_next_pc: got %h want %h", PC, 32'h40); end
    endtask

    task automatic test_hysteresis();
        redirect_to(32'h10);
        // 10 -> 11, then a third taken must saturate rather than wrap
        for (int i = 0; i < 3; i++) train(32'h10, 1'b1, 32'h40);
        n_cmp++; if (pred_taken !== 1'b1) begin n_err++; $display("FAIL hyst_strong: got %b want 1", pred_taken); end
        train(32'h10, 1'b0, 32'h0);
        n_cmp++; if (pred_taken !== 1'b1) begin n_err++; $display("FAIL hyst_weak_taken: got %b want 1", pred_taken); end
        n_cmp++; if (pred_target !== 32'h40) begin n_err++; $display("FAIL hyst_weak_target: got %h want %h", pred_target, 32'h40); end
        train(32'h10, 1'b0, 32'h0);
        n_cmp++; if (pred_taken !== 1'b0) begin n_err++; $display("FAIL hyst_not_taken: got %b want 0", pred_taken); end
        n_cmp++; if (pred_target !== 32'h14) begin n_err++; $display("FAIL hyst_nt_target: got %h want %h", pred_target, 32'h14); end
        step();
        n_cmp++; if (PC !== 32'h14) begin n_err++; $display("FAIL hyst_next_pc: got %h want %h", PC, 32'h14); end
    endtask

    task automatic test_redirect_stall();
        stall       = 1'b1;
        redirect_en = 1'b1;
        redirect_pc = 32'h103;
        step();
        redirect_en = 1'b0;
        n_cmp++; if (PC !== 32'h100) begin n_err++; $display("FAIL redirect_over_stall: got %h want %h", PC, 32'h100); end
        step();
        n_cmp++; if (PC !== 32'h100) begin n_err++; $display("FAIL stall_hold: got %h want %h", PC, 32'h100); end
        stall = 1'b0;
        step();
        n_cmp++; if (PC !== 32'h104) begin n_err++; $display("FAIL stall_release: got %h want %h", PC, 32'h104); end
    endtask

    task automatic test_alias();
        // Entry at 0x10 sits at ctr=01; one taken update brings it back to 10
        train(32'h10, 1'b1, 32'h40);
        redirect_to(32'h50);
        n_cmp++; if (pred_taken !== 1'b0) begin n_err++; $display("FAIL alias_miss: got %b want 0", pred_taken); end
        n_cmp++; if (pred_target !== 32'h54) begin n_err++; $display("FAIL alias_miss_target: got %h want %h", pred_target, 32'h54); end
        train(32'h50, 1'b1, 32'h80);
        n_cmp++; if (pred_taken !== 1'b1) begin n_err++; $display("FAIL alias_new_taken: got %b want 1", pred_taken); end
        n_cmp++; if (pred_target !== 32'h80) begin n_err++; $display("FAIL alias_new_target: got %h want %h", pred_target, 32'h80); end
        redirect_to(32'h10);
        n_cmp++; if (pred_taken !== 1'b0) begin n_err++; $display("FAIL alias_evicted: got %b want 0", pred_taken); end
        n_cmp++; if (pred_target !== 32'h14) begin n_err++; $display("FAIL alias_evicted_target: got %h want %h", pred_target, 32'h14); end
    endtask

    task automatic test_same_cycle_and_reset();
        do_reset();
        redirect_to(32'h10);
        upd_en     = 1'b1;
        upd_pc     = 32'h10;
        upd_taken  = 1'b1;
        upd_target = 32'h200;
        step();
        upd_en = 1'b0;
        n_cmp++; if (PC !== 32'h14) begin n_err++; $display("FAIL same_cycle_next_pc: got %h want %h", PC, 32'h14); end
        redirect_to(32'h10);
        n_cmp++; if (pred_target !== 32'h200) begin n_err++; $display("FAIL same_cycle_trained: got %h want %h", pred_target, 32'h200); end
        // Reset with a concurrent update: training is discarded and the update ignored
        rst        = 1'b1;
        upd_en     = 1'b1;
        upd_pc     = 32'h20;
        upd_taken  = 1'b1;
        upd_target = 32'h300;
        step();
        rst    = 1'b0;
        upd_en = 1'b0;
        n_cmp++; if (PC !== 32'h0) begin n_err++; $display("FAIL mid_reset_pc: got %h want %h", PC, 32'h0); end
        redirect_to(32'h10);
        n_cmp++; if (pred_taken !== 1'b0) begin n_err++; $display("FAIL mid_reset_cleared: got %b want 0", pred_taken); end
        redirect_to(32'h20);
        n_cmp++; if (pred_taken !== 1'b0) begin n_err++; $display("FAIL reset_upd_ignored: got %b want 0", pred_taken); end
    endtask

    task automatic test_wrap();
        redirect_to(32'hFFFF_FFFC);
        n_cmp++; if (pred_target !== 32'h0) begin n_err++; $display("FAIL wrap_target: got %h want %h", pred_target, 32'h0); end
        step();
        n_cmp++; if (PC !== 32'h0) begin n_err++; $display("FAIL wrap_pc: got %h want %h", PC, 32'h0); end
    endtask

    initial begin
        test_reset();
        test_allocate();
        test_hysteresis();
        test_redirect_stall();
        test_alias();
        test_same_cycle_and_reset();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
